// File: rtl/gyro_sdm_driver.sv
// gyro_sdm_driver: first-order sigma-delta pbus/nbus driver with dead time; define GYRO_SDM_DITHER_EN to add LFSR dither
module gyro_sdm_driver #(
  parameter int DW       = 12,
  parameter int OSR_LOG2 = 6,
  parameter int DT_CYC   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] code,
  input  logic          code_valid,
  output logic          code_ready,
  output logic          drv_p,
  output logic          drv_n,
  output logic          frame_tick,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
  state_t              state, state_nx;
  logic [DW-1:0]       acc, code_reg;
  logic [OSR_LOG2-1:0] fcnt;
  logic [2:0]          dcnt;
  logic                last_bit, sbit, step, p_nx, n_nx;
  logic [DW:0]         sum;
  assign step = state == RUN && en;
`ifdef GYRO_SDM_DITHER_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr <= 16'hACE1;
    else if (step) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign sum = {1'b0, acc} + {1'b0, code_reg} + {{DW{1'b0}}, lfsr[0]};
`else
  assign sum = {1'b0, acc} + {1'b0, code_reg};
`endif
  assign sbit = sum[DW];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (en ? RUN : IDLE)
             : state == RUN  ? (!en ? IDLE : sbit != last_bit ? DEAD : RUN)
             : state == DEAD ? (dcnt != 3'd0 ? DEAD : en ? RUN : IDLE)
             : IDLE;
  end
  // code_ready is gated by rst_n so every output reads low while reset is held
  always_comb begin
    busy       = state != IDLE;
    frame_tick = state == RUN && &fcnt;
    code_ready = rst_n && (state == IDLE || frame_tick);
    p_nx = state == RUN ? (en && sbit == last_bit && sbit)
                        : (state == DEAD && dcnt == 3'd0 && en && last_bit);
    n_nx = state == RUN ? (en && sbit == last_bit && !sbit)
                        : (state == DEAD && dcnt == 3'd0 && en && !last_bit);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc      <= '0;
      code_reg <= '0;
      fcnt     <= '0;
      dcnt     <= '0;
      last_bit <= 1'b0;
      drv_p    <= 1'b0;
      drv_n    <= 1'b0;
    end else begin
      if (code_valid && code_ready) code_reg <= code;
      drv_p <= p_nx;
      drv_n <= n_nx;
      if (step) begin
        acc  <= sum[DW-1:0];
        fcnt <= fcnt + 1'b1;
        if (sbit != last_bit) begin
          last_bit <= sbit;
          dcnt     <= 3'(DT_CYC - 1);
        end
      end else if (state == DEAD && dcnt != 3'd0) dcnt <= dcnt - 1'b1;
      // leaving for IDLE restarts the modulator so re-enable matches a cold start
      if (state_nx == IDLE) begin
        acc      <= '0;
        fcnt     <= '0;
        last_bit <= 1'b0;
      end
    end
endmodule

// File: tb/tb_gyro_sdm_driver.sv
// tb_gyro_sdm_driver: directed vector table plus multi-cycle sequences for gyro_sdm_driver
module tb_gyro_sdm_driver;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, code_valid = 1'b0;
  logic [11:0] code = '0;
  logic        code_ready, drv_p, drv_n, frame_tick, busy;
  int          n_checks = 0, n_fail = 0;

  gyro_sdm_driver dut (
    .clk(clk), .rst_n(rst_n), .en(en), .code(code), .code_valid(code_valid),
    .code_ready(code_ready), .drv_p(drv_p), .drv_n(drv_n),
    .frame_tick(frame_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        vld;
    logic [11:0] code;
    logic [4:0]  exp;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {drv_p, drv_n, code_ready, frame_tick, busy};
  endfunction

  task automatic run_table(input string tag);
    for (int i = 0; i < 16; i++) begin
      en = tbl[i].en; code_valid = tbl[i].vld; code = tbl[i].code;
      @(posedge clk); @(negedge clk);
      chk($sformatf("%s_row%0d {p,n,rdy,tick,busy}", tag, i), int'(outs()), int'(tbl[i].exp));
    end
    code_valid = 1'b0;
  endtask

  task automatic go_idle();
    int k;
    en = 1'b0; code_valid = 1'b0;
    k = 0;
    while (busy && k < 20) begin
      @(posedge clk); @(negedge clk); k++;
    end
    chk("go_idle busy", int'(busy), 0);
  endtask

  task automatic start(input logic [11:0] c);
    en = 1'b1; code_valid = 1'b1; code = c;
    @(posedge clk); @(negedge clk);
    code_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, bad, np, nn, nov, cyc, ones, seen, skip, ok;
    // code 2048 from cold start; en dropped inside a dead window at rows 9-10, re-enabled at 11
    tbl[0]  = '{1'b1, 1'b1, 12'd2048, 5'b00001};
    tbl[1]  = '{1'b1, 1'b0, 12'd0,    5'b01001};
    tbl[2]  = '{1'b1, 1'b0, 12'd0,    5'b00001};
    tbl[3]  = '{1'b1, 1'b0, 12'd0,    5'b00001};
    tbl[4]  = '{1'b1, 1'b0, 12'd0,    5'b10001};
    tbl[5]  = '{1'b1, 1'b0, 12'd0,    5'b00001};
    tbl[6]  = '{1'b1, 1'b0, 12'd0,    5'b00001};
    tbl[7]  = '{1'b1, 1'b0, 12'd0,    5'b01001};
    tbl[8]  = '{1'b1, 1'b0, 12'd0,    5'b00001};
    tbl[9]  = '{1'b0, 1'b0, 12'd0,    5'b00001};
    tbl[10] = '{1'b0, 1'b0, 12'd0,    5'b00100};
    tbl[11] = '{1'b1, 1'b0, 12'd0,    5'b00001};
    tbl[12] = '{1'b1, 1'b0, 12'd0,    5'b01001};
    tbl[13] = '{1'b1, 1'b0, 12'd0,    5'b00001};
    tbl[14] = '{1'b1, 1'b0, 12'd0,    5'b00001};
    tbl[15] = '{1'b1, 1'b0, 12'd0,    5'b10001};

    @(negedge clk); @(negedge clk);
    chk("reset outputs", int'(outs()), 0);
    rst_n = 1'b1;
    run_table("cold");

    // code 0: constant drv_n, no dead windows, frame_tick every 64 clocks
    go_idle();
    start(12'd0);
    prev = -1; bad = 0;
    for (int j = 0; j < 500; j++) begin
      if (j > 0) begin
        @(posedge clk); @(negedge clk);
        if (!(drv_n && !drv_p)) bad++;
      end
      if (frame_tick) begin
        chk($sformatf("code0 tick interval at %0d", j), j - prev, 64);
        prev = j;
      end
    end
    chk("code0 non-constant drive cycles", bad, 0);

    // code 1024 for 4096 steps: each step shows as exactly one driven clock
    go_idle();
    start(12'd1024);
    np = 0; nn = 0; nov = 0; cyc = 0;
    while (np + nn < 4096 && cyc < 20000) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (drv_p && drv_n) nov++;
      else if (drv_p) np++;
      else if (drv_n) nn++;
    end
    chk("code1024 steps completed", np + nn, 4096);
    chk("code1024 ones in 4096 steps", np, 1024);
    chk("code1024 overlap cycles", nov, 0);

    // mid-run offer of 3072: only accepted on the frame_tick clock
    code = 12'd3072; code_valid = 1'b1;
    bad = 0; ok = 0;
    for (int j = 0; j < 200 && !ok; j++) begin
      if (code_ready != frame_tick) bad++;
      if (code_ready) ok = 1;
      else begin
        @(posedge clk); @(negedge clk);
      end
    end
    chk("offer accepted within bound", ok, 1);
    chk("code_ready outside frame_tick", bad, 0);
    @(posedge clk); #1 code_valid = 1'b0;
    ones = 0; seen = 0; skip = 1; nov = 0; cyc = 0;
    while (seen < 400 && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (drv_p && drv_n) nov++;
      if (drv_p || drv_n) begin
        if (skip) skip = 0;
        else begin
          seen++;
          if (drv_p) ones++;
        end
      end
      @(posedge clk);
    end
    chk("code3072 steps observed", seen, 400);
    chk("code3072 ones in 400 steps", ones, 300);
    chk("code3072 overlap cycles", nov, 0);

    // asynchronous reset pulse mid-run, then a cold-start replay
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk("async reset outputs", int'(outs()), 0);
    @(posedge clk); @(negedge clk);
    chk("held reset outputs", int'(outs()), 0);
    en = 1'b0; rst_n = 1'b1;
    run_table("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
